serial_read_buffer: RTL
=======================

SERIAL_READ_BUFFER -- requirements
Module: serial_read_buffer

Interface
REQ-001 SHALL have parameter BUF_SIZE, default 8, meaning the maximum number of bits captured per transfer and the width of data_out.
REQ-002 SHALL have port sys_clk  input  1  system clock; all logic runs on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a capture.
REQ-005 SHALL have port read_sig  input  1  one-sys_clk-cycle sample strobe, already synchronised to sys_clk.
REQ-006 SHALL have port data_in  input  1  serial data line.
REQ-007 SHALL have port read_count  input  clog2(BUF_SIZE+1)  number of bits to capture.
REQ-008 SHALL have port data_out  output  BUF_SIZE  captured word, MSB-first, left-aligned.
REQ-009 SHALL have port done_sig  output  1  high while idle or finished; low while capturing.

Function
REQ-010 SHALL implement two states:
 - IDLE: done_sig=1.
 - READ: done_sig=0.
REQ-011 In IDLE, start=1 SHALL latch read_count, clear the internal bit index, and enter READ on the next edge.
REQ-012 A read_count greater than BUF_SIZE SHALL be clamped to BUF_SIZE at the latch.
REQ-013 A latched count of 0 SHALL remain in IDLE, set data_out to all zeros, and keep done_sig=1.
REQ-014 read_sig SHALL be ignored in the cycle start is accepted; sampling begins the following cycle.
REQ-015 In READ, each read_sig=1 cycle SHALL sample data_in and decrement the remaining count by 1.
REQ-016 The k-th sampled bit (k=0..n-1) SHALL be stored at bit position BUF_SIZE-1-k.
REQ-017 Bit positions BUF_SIZE-n-1 down to 0 SHALL read 0 after completion.
REQ-018 data_out SHALL change only when a capture completes, and SHALL hold that value until the next completion or reset.
REQ-019 Partial captures SHALL never appear on data_out.
REQ-020 When the n-th read_sig is sampled at edge t, data_out SHALL be valid, done_sig SHALL be 1, and the state SHALL be IDLE at edge t+1 (one-cycle latency).
REQ-021 start while in READ SHALL be ignored.
REQ-022 read_sig while in IDLE SHALL be ignored.
REQ-023 start and read_sig in the same IDLE cycle SHALL accept start and discard the strobe.
REQ-024 read_count changes after the latch SHALL have no effect on the capture in progress.
REQ-025 A new start SHALL be accepted in the first cycle after completion (back-to-back captures).

Reset
REQ-026 rst=1 SHALL asynchronously force:
 - state IDLE
 - data_out all zeros
 - done_sig 1
 - bit index and count 0
REQ-027 rst asserted mid-capture SHALL abort the capture; no partial data reaches data_out.
REQ-028 After rst deasserts, strobes SHALL be ignored until a new start.

Structure
REQ-029 The state encoding (IDLE, READ) and the count-width expression clog2(BUF_SIZE+1) SHALL live in the shared serial-buffer constants package, also used by the write buffer.
REQ-030 No sub-module is required.
REQ-031 read_sig SHALL be produced outside this block by the existing edge-detector module, configured for the rising edge of the serial clock.

Verification
REQ-032 BUF_SIZE=8: start, read_count=8, data_in bits 1,0,0,1,1,1,0,0 on 8 strobes -> data_out=0x9C and done_sig=1 one cycle after the 8th strobe; done_sig=0 throughout.
REQ-033 read_count=6, bits 1,1,1,1,0,0 -> data_out=0xF0; an extra strobe afterwards leaves data_out=0xF0.
REQ-034 read_count=6, rst pulsed after 3 strobes -> data_out=0x00 and done_sig=1 immediately; the remaining 3 strobes leave data_out=0x00.
REQ-035 read_count=4, bits 0,1,0,1 -> data_out=0x50; a second start issued after strobe 2 is ignored and the result is still 0x50.
REQ-036 read_count=0 -> done_sig stays 1 and data_out=0x00.
REQ-037 read_count=12 -> clamped to 8 and completes after exactly 8 strobes.
REQ-038 start coincident with read_sig (data_in=1) -> that bit is not captured; the next 8 strobes of 0x3C give data_out=0x3C.

Source files
------------

// File: rtl/serial_read_buffer_pkg.sv
// rtl/serial_read_buffer_pkg.sv - shared serial-buffer constants: state encoding and count width
package serial_read_buffer_pkg;

    // Capture state shared by the read and write serial buffers
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } srb_state_t;

    // Width of a bit count able to hold 0..buf_size inclusive
    function automatic int count_width(input int buf_size);
        return $clog2(buf_size + 1);
    endfunction

endpackage

// File: rtl/serial_read_buffer.sv
// rtl/serial_read_buffer.sv - captures up to BUF_SIZE serial bits MSB-first on strobes, publishes whole words only
module serial_read_buffer
    import serial_read_buffer_pkg::*;
#(
    parameter int BUF_SIZE = 8
)
(
    input  logic                               sys_clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               read_sig,
    input  logic                               data_in,
    input  logic [count_width(BUF_SIZE)-1:0]   read_count,
    output logic [BUF_SIZE-1:0]                data_out,
    output logic                               done_sig
);

    localparam int               CNT_W   = count_width(BUF_SIZE);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(BUF_SIZE);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    srb_state_t          r_state;
    logic [CNT_W-1:0]    r_remaining;
    logic [CNT_W-1:0]    r_bit_idx;
    logic [BUF_SIZE-1:0] r_shadow;
    logic [BUF_SIZE-1:0] r_data_out;
    logic                r_done;

    logic [CNT_W-1:0]    w_clamped;
    logic [BUF_SIZE-1:0] w_shadow_next;
    logic                w_last_bit;

    // Requested count clamped to the buffer width before it is latched
    always_comb begin
        w_clamped = (read_count > MAX_CNT) ? MAX_CNT : read_count;
    end

    // Shadow word with the current sample placed at its left-aligned position
    always_comb begin
        w_shadow_next = r_shadow;
        for (int i = 0; i < BUF_SIZE; i++) begin
            if (i == (BUF_SIZE - 1 - int'(r_bit_idx))) begin
                w_shadow_next[i] = data_in;
            end
        end
    end

    // The strobe being sampled now is the final one of this capture
    always_comb begin
        w_last_bit = (r_remaining == ONE_CNT);
    end

    // Capture FSM; bits accumulate in a shadow register so data_out only moves on completion
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_bit_idx   <= '0;
            r_shadow    <= '0;
            r_data_out  <= '0;
            r_done      <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A strobe coinciding with start is dropped: sampling only happens in ST_READ
                    if (start) begin
                        r_bit_idx <= '0;
                        r_shadow  <= '0;
                        if (w_clamped == '0) begin
                            r_remaining <= '0;
                            r_data_out  <= '0;
                        end else begin
                            r_remaining <= w_clamped;
                            r_state     <= ST_READ;
                            r_done      <= 1'b0;
                        end
                    end
                end
                ST_READ: begin
                    if (read_sig) begin
                        r_shadow    <= w_shadow_next;
                        r_bit_idx   <= r_bit_idx + ONE_CNT;
                        r_remaining <= r_remaining - ONE_CNT;
                        if (w_last_bit) begin
                            r_data_out <= w_shadow_next;
                            r_state    <= ST_IDLE;
                            r_done     <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign data_out = r_data_out;
    assign done_sig = r_done;

endmodule
